// File: rtl/ntt_pkg.sv
// Shared types, constants and butterfly index arithmetic for the Kyber forward NTT.
// ZETAS holds the reference twiddles reduced into [0, q) in Montgomery form.
package ntt_pkg;
    localparam int MOD_Q  = 3329;
    localparam int QINV   = 62209;
    localparam int ZETA_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_e;
    typedef logic [7:0] coeff_idx_t;

    typedef struct packed {
        coeff_idx_t left;
        coeff_idx_t right;
        logic [6:0] k;
    } bf_cmd_t;

    localparam logic [ZETA_W-1:0] ZETAS [128] = '{
        16'd2285, 16'd2571, 16'd2970, 16'd1812, 16'd1493, 16'd1422, 16'd287,  16'd202,
        16'd3158, 16'd622,  16'd1577, 16'd182,  16'd962,  16'd2127, 16'd1855, 16'd1468,
        16'd573,  16'd2004, 16'd264,  16'd383,  16'd2500, 16'd1458, 16'd1727, 16'd3199,
        16'd2648, 16'd1017, 16'd732,  16'd608,  16'd1787, 16'd411,  16'd3124, 16'd1758,
        16'd1223, 16'd652,  16'd2777, 16'd1015, 16'd2036, 16'd1491, 16'd3047, 16'd1785,
        16'd516,  16'd3321, 16'd3009, 16'd2663, 16'd1711, 16'd2167, 16'd126,  16'd1469,
        16'd2476, 16'd3239, 16'd3058, 16'd830,  16'd107,  16'd1908, 16'd3082, 16'd2378,
        16'd2931, 16'd961,  16'd1821, 16'd2604, 16'd448,  16'd2264, 16'd677,  16'd2054,
        16'd2226, 16'd430,  16'd555,  16'd843,  16'd2078, 16'd871,  16'd1550, 16'd105,
        16'd422,  16'd587,  16'd177,  16'd3094, 16'd3038, 16'd2869, 16'd1574, 16'd1653,
        16'd3083, 16'd778,  16'd1159, 16'd3182, 16'd2552, 16'd1483, 16'd2727, 16'd1119,
        16'd1739, 16'd644,  16'd2457, 16'd349,  16'd418,  16'd329,  16'd3173, 16'd3254,
        16'd817,  16'd1097, 16'd603,  16'd610,  16'd1322, 16'd2044, 16'd1864, 16'd384,
        16'd2114, 16'd3193, 16'd1218, 16'd1994, 16'd2455, 16'd220,  16'd2142, 16'd1670,
        16'd2144, 16'd1799, 16'd2051, 16'd794,  16'd1819, 16'd2475, 16'd2459, 16'd478,
        16'd3221, 16'd3021, 16'd996,  16'd991,  16'd958,  16'd1869, 16'd1522, 16'd1628
    };

    // Group stride is 2*len; shifts and masks keep the index path free of muxes.
    function automatic bf_cmd_t bf_cmd(input logic [2:0] layer, input logic [6:0] b);
        logic [2:0] s;
        coeff_idx_t bw;
        coeff_idx_t len;
        bf_cmd_t    c;
        s       = 3'd7 - layer;
        bw      = {1'b0, b};
        len     = 8'd1 << s;
        c.left  = ((bw >> s) << ({1'b0, s} + 4'd1)) | (bw & (len - 8'd1));
        c.right = c.left + len;
        c.k     = (7'd1 << layer) + (b >> s);
        return c;
    endfunction
endpackage

// File: rtl/ntt_layer_sequencer_zeta_rom.sv
// Combinational twiddle lookup: 7-bit zeta index to W-bit Montgomery-domain zeta.
module ntt_zeta_rom
    import ntt_pkg::*;
#(
    parameter int W = ZETA_W
) (
    input  logic [6:0]   addr_i,
    output logic [W-1:0] zeta_o
);
    assign zeta_o = W'(ZETAS[addr_i]);
endmodule

// File: rtl/ntt_layer_sequencer.sv
// Issues the 7x128 butterfly commands of a forward NTT, draining in-flight work between layers.
// Command outputs are registered (valid the cycle after start); held stable while bf_ready_i is low.
module ntt_layer_sequencer
    import ntt_pkg::*;
#(
    parameter int W       = ZETA_W,
    parameter int LAYERS  = 7,
    parameter int N_BF    = 128,
    parameter int OUTST_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             bf_valid_o,
    input  logic             bf_ready_i,
    output logic [7:0]       left_idx_o,
    output logic [7:0]       right_idx_o,
    output logic [W-1:0]     twiddle_o,
    input  logic             bf_out_valid_i,
    output logic [2:0]       layer_o,
    output logic             err_o
);
    seq_state_e         r_state, w_state_nxt;
    logic [2:0]         r_layer, w_cmd_layer;
    logic [6:0]         r_b, w_cmd_b;
    logic               r_valid, w_valid_nxt;
    logic               r_done, w_done_nxt;
    logic               w_load;
    coeff_idx_t         r_left, r_right;
    logic [W-1:0]       r_twiddle;
    logic [OUTST_W-1:0] r_outst;
    logic               r_err;
    logic               w_xfer, w_dec;
    bf_cmd_t            w_cmd;
    logic [W-1:0]       w_zeta;

    assign w_xfer = r_valid & bf_ready_i;
    // A completion paired with an issue leaves the count unchanged even at zero.
    assign w_dec  = bf_out_valid_i & ((r_outst != '0) | w_xfer);
    assign w_cmd  = bf_cmd(w_cmd_layer, w_cmd_b);

    ntt_zeta_rom #(.W(W)) u_zeta_rom (
        .addr_i (w_cmd.k),
        .zeta_o (w_zeta)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cmd_layer = r_layer;
        w_cmd_b     = r_b;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = ISSUE;
                    w_load      = 1'b1;
                    w_cmd_layer = 3'd0;
                    w_cmd_b     = 7'd0;
                    w_valid_nxt = 1'b1;
                end
            end
            ISSUE: begin
                if (w_xfer) begin
                    if (r_b == 7'(N_BF - 1)) begin
                        w_state_nxt = DRAIN;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_load  = 1'b1;
                        w_cmd_b = r_b + 7'd1;
                    end
                end
            end
            DRAIN: begin
                if (r_outst == '0) begin
                    if (r_layer == 3'(LAYERS - 1)) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_load      = 1'b1;
                        w_cmd_layer = r_layer + 3'd1;
                        w_cmd_b     = 7'd0;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_layer   <= '0;
            r_b       <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
            r_twiddle <= '0;
            r_outst   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_outst <= r_outst + OUTST_W'(w_xfer) - OUTST_W'(w_dec);
            r_err   <= r_err | (bf_out_valid_i & (r_outst == '0));
            if (w_load) begin
                r_layer   <= w_cmd_layer;
                r_b       <= w_cmd_b;
                r_left    <= w_cmd.left;
                r_right   <= w_cmd.right;
                r_twiddle <= w_zeta;
            end
        end
    end

    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign bf_valid_o  = r_valid;
    assign left_idx_o  = r_left;
    assign right_idx_o = r_right;
    assign twiddle_o   = r_twiddle;
    assign layer_o     = r_layer;
    assign err_o       = r_err;
endmodule
